// File: rtl/aes_iter_encrypt.sv
// aes_iter_encrypt: iterative AES-128/AES-256 encryptor. It computes one round
// per clock. Round keys are expanded on the fly, so a single bank of 16 state
// S-boxes and a single bank of 4 key S-boxes serve every round.
//
// Ports:
//   clk        : clock; all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : text/key are valid (accepted when in_ready is high)
//   in_ready   : high in IDLE; a new job can be accepted
//   text[127:0]: plaintext; bit 127 is state byte 0
//   key        : cipher key, KEY_BITS wide; bit KEY_BITS-1 is key byte 0
//   out_valid  : high in DONE; citxt holds a finished ciphertext
//   out_ready  : sink takes citxt this cycle (only looked at in DONE)
//   citxt      : ciphertext, in the same byte order as text
//   busy       : high while rounds are being computed
module aes_iter_encrypt #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        text,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        citxt,
  output logic                busy
);

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [127:0]        st_q, st_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [127:0]        citxt_q, citxt_d;

  logic [127:0]        sub_st;
  logic [127:0]        sr_st;
  logic [127:0]        round_out;
  logic [31:0]         key_sub_in;
  logic [31:0]         key_sub_out;
  logic [127:0]        rk;
  logic [KEY_BITS-1:0] key_next;
  logic                rcon_used;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the state sits at bits [127-8n -: 8]; column c = n/4, row r = n%4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Shared S-box banks: 16 for the state, 4 for the key schedule word.
  for (genvar i = 0; i < 16; i++) begin : g_st_sbox
    sbox u_sbox (.a(st_q[127-8*i -: 8]), .y(sub_st[127-8*i -: 8]));
  end

  // The last key word feeds the key S-boxes for both key sizes; RotWord is
  // applied after substitution since both are byte-wise.
  assign key_sub_in = key_q[31:0];

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    sbox u_sbox (.a(key_sub_in[31-8*i -: 8]), .y(key_sub_out[31-8*i -: 8]));
  end

  if (KEY_BITS == 128) begin : g_k128
    logic [31:0] t, n0, n1, n2, n3;
    // key_q holds round key rnd-1; derive round key rnd every round.
    always_comb begin
      t         = {key_sub_out[23:0], key_sub_out[31:24]} ^ {rcon_q, 24'h0};
      n0        = key_q[127:96] ^ t;
      n1        = key_q[95:64]  ^ n0;
      n2        = key_q[63:32]  ^ n1;
      n3        = key_q[31:0]   ^ n2;
      rk        = {n0, n1, n2, n3};
      key_next  = {n0, n1, n2, n3};
      rcon_used = 1'b1;
    end
  end else if (KEY_BITS == 256) begin : g_k256
    logic [31:0] t, n0, n1, n2, n3;
    logic        even_rnd;
    // Round 1 uses the lower half of the original key unchanged. From round
    // 2, key_q holds the previous 8 words and the 4 new ones are appended.
    always_comb begin
      even_rnd = ~rnd_q[0];
      if (even_rnd) t = {key_sub_out[23:0], key_sub_out[31:24]} ^ {rcon_q, 24'h0};
      else          t = key_sub_out;
      n0 = key_q[255:224] ^ t;
      n1 = key_q[223:192] ^ n0;
      n2 = key_q[191:160] ^ n1;
      n3 = key_q[159:128] ^ n2;
      if (rnd_q == 4'd1) begin
        rk        = key_q[127:0];
        key_next  = key_q;
        rcon_used = 1'b0;
      end else begin
        rk        = {n0, n1, n2, n3};
        key_next  = {key_q[127:0], n0, n1, n2, n3};
        rcon_used = even_rnd;
      end
    end
  end else begin : g_bad_key_bits
    $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
  end

  // Round datapath: SubBytes -> ShiftRows -> MixColumns (not on last round) -> AddRoundKey
  always_comb begin
    sr_st = shift_rows(sub_st);
    if (rnd_q == NR) round_out = sr_st ^ rk;
    else             round_out = mix_columns(sr_st) ^ rk;
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    citxt_d = citxt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = text ^ key[KEY_BITS-1 -: 128];
          key_d   = key;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        st_d  = round_out;
        key_d = key_next;
        rnd_d = rnd_q + 4'd1;
        // rcon is left at its last used value so it never runs past the schedule.
        if (rcon_used && (rnd_q != NR)) rcon_d = xtime(rcon_q);
        if (rnd_q == NR) begin
          citxt_d = round_out;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
      citxt_q <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      citxt_q <= citxt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign citxt     = citxt_q;

endmodule

// sbox: combinational AES S-box, computed as the GF(2^8) inverse (x^254)
// followed by the AES affine transform.
// Ports: a = input byte, y = substituted byte.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = product of x^(2^k) for k = 1..7; maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Testbench for aes_iter_encrypt: one AES-128 and one AES-256 instance driven
// with directed FIPS-197 vectors and random jobs, compared against a
// table-driven AES reference model with a full precomputed key schedule.
module tb_aes_iter_encrypt;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_text, a_key, a_citxt;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_text, b_citxt;
  logic [255:0] b_key;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   rcon_max = 8'h00;

  logic [7:0]   ex_t [256];
  int           lg_t [256];
  logic [7:0]   sb_t [256];

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] T1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KC3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CC3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  always #5 clk = ~clk;

  aes_iter_encrypt #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .text(a_text), .key(a_key), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .citxt(a_citxt), .busy(a_busy)
  );

  aes_iter_encrypt #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .text(b_text), .key(b_key), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .citxt(b_citxt), .busy(b_busy)
  );

  // Largest rcon value the AES-256 instance ever holds while computing rounds.
  always @(negedge clk) begin
    if (b_busy && (u256.rcon_q > rcon_max)) rcon_max = u256.rcon_q;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] p);
    return {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
  endfunction

  // Log/antilog tables over generator 3, then S-box = affine(inverse).
  task automatic build_tables();
    logic [7:0] p, inv, o;
    logic [7:0] c;
    c = 8'h63;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex_t[i] = p;
      lg_t[p] = i;
      p = p ^ xt(p);
    end
    ex_t[255] = ex_t[0];
    lg_t[0]   = 0;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex_t[(255 - lg_t[x]) % 255];
      for (int i = 0; i < 8; i++)
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb_t[x] = o;
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return ex_t[(lg_t[a] + lg_t[b]) % 255];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_t[x[31:24]], sb_t[x[23:16]], sb_t[x[15:8]], sb_t[x[7:0]]};
  endfunction

  // Key is left-aligned in k; nk = 4 (AES-128) or 8 (AES-256).
  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [255:0] k, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gm(8'h02, t[4*c]) ^ gm(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(8'h02, t[4*c+1]) ^ gm(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(8'h02, t[4*c+2]) ^ gm(8'h03, t[4*c+3]);
          s[4*c+3] = gm(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gm(8'h02, t[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Present one job while the instance is idle, then wait (bounded) for out_valid.
  task automatic do_job(input bit wide, input logic [127:0] t, input logic [255:0] k,
                        output logic [127:0] ct, output int lat);
    if (wide) begin b_in_valid = 1'b1; b_text = t; b_key = k; end
    else      begin a_in_valid = 1'b1; a_text = t; a_key = k[255:128]; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    chk_b("busy_after_accept", wide ? b_busy : a_busy, 1'b1);
    lat = 0;
    while (!(wide ? b_out_valid : a_out_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ct = wide ? b_citxt : a_citxt;
  endtask

  task automatic release_out(input bit wide);
    if (wide) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    chk_b("release_in_ready", wide ? b_in_ready : a_in_ready, 1'b1);
    chk_b("release_out_valid", wide ? b_out_valid : a_out_valid, 1'b0);
  endtask

  initial begin
    logic [127:0] ct, exp_ct, ta, tb2;
    logic [255:0] ka, kb;
    int           lat, hi_cnt, idx, n_out, cyc;
    bit           acc;
    int           acc_cyc [3];
    int           out_cyc [3];
    logic [127:0] got [3];
    logic [127:0] st_t [3];
    logic [255:0] st_k [3];

    build_tables();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_text = '0; a_key = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_text = '0; b_key = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_in_ready", a_in_ready, 1'b1);
    chk_b("rst_out_valid", a_out_valid, 1'b0);
    chk_b("rst_busy", a_busy, 1'b0);
    chk("rst_citxt", a_citxt, 128'h0);
    chk_b("rst_in_ready_256", b_in_ready, 1'b1);
    chk("rst_citxt_256", b_citxt, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AES-128 appendix B vector
    do_job(1'b0, T1, {K1, 128'h0}, ct, lat);
    chk_i("aes128_b_latency", lat, 10);
    chk("aes128_b_citxt", ct, C1);
    release_out(1'b0);

    // AES-128 C.1
    do_job(1'b0, TC, {KC1, 128'h0}, ct, lat);
    chk("aes128_c1_citxt", ct, CC1);
    release_out(1'b0);

    // AES-256 C.3
    do_job(1'b1, TC, KC3, ct, lat);
    chk_i("aes256_c3_latency", lat, 14);
    chk("aes256_c3_citxt", ct, CC3);
    chk_i("aes256_rcon_peak", int'(rcon_max), 32'h40);
    release_out(1'b1);

    // Random jobs against the reference model
    for (int i = 0; i < 4; i++) begin
      ta = rnd128();
      ka = {rnd128(), 128'h0};
      do_job(1'b0, ta, ka, ct, lat);
      chk_i("rand128_latency", lat, 10);
      chk("rand128_citxt", ct, ref_aes(ta, ka, 4));
      release_out(1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      ta = rnd128();
      ka = {rnd128(), rnd128()};
      do_job(1'b1, ta, ka, ct, lat);
      chk("rand256_citxt", ct, ref_aes(ta, ka, 8));
      release_out(1'b1);
    end
    chk_i("aes256_rcon_bound", int'(rcon_max), 32'h40);

    // Back-pressure with input churn
    ta = rnd128();
    ka = {rnd128(), 128'h0};
    exp_ct = ref_aes(ta, ka, 4);
    do_job(1'b0, ta, ka, ct, lat);
    chk("bp_first_citxt", ct, exp_ct);
    for (int i = 0; i < 20; i++) begin
      a_in_valid = 1'($urandom_range(0, 1));
      a_text = rnd128();
      a_key  = rnd128();
      @(posedge clk); #1;
      chk("bp_citxt_hold", a_citxt, exp_ct);
      chk_b("bp_in_ready", a_in_ready, 1'b0);
      chk_b("bp_out_valid", a_out_valid, 1'b1);
    end
    tb2 = rnd128();
    kb  = {rnd128(), 128'h0};
    a_in_valid = 1'b1; a_text = tb2; a_key = kb[255:128]; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk_b("bp_idle_after_pulse", a_in_ready, 1'b1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk_b("bp_second_accept", a_busy, 1'b1);
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_i("bp_second_latency", lat, 10);
    chk("bp_second_citxt", a_citxt, ref_aes(tb2, kb, 4));
    release_out(1'b0);

    // Reset in the middle of round 5
    a_in_valid = 1'b1; a_text = TC; a_key = KC1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_b("midrst_in_ready", a_in_ready, 1'b1);
    chk_b("midrst_busy", a_busy, 1'b0);
    chk("midrst_citxt", a_citxt, 128'h0);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) hi_cnt++;
    end
    chk_i("midrst_no_output", hi_cnt, 0);
    chk_b("midrst_in_ready_later", a_in_ready, 1'b1);
    do_job(1'b0, TC, {KC1, 128'h0}, ct, lat);
    chk("midrst_c1_citxt", ct, CC1);
    release_out(1'b0);

    // Back-to-back streaming, in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      st_t[i] = rnd128();
      st_k[i] = {rnd128(), 128'h0};
    end
    idx = 0; n_out = 0; cyc = 0;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_text = st_t[0]; a_key = st_k[0][255:128];
    while (n_out < 3 && cyc < 200) begin
      acc = a_in_ready && a_in_valid;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin a_text = st_t[idx]; a_key = st_k[idx][255:128]; end
        else a_in_valid = 1'b0;
      end
      if (a_out_valid) begin
        out_cyc[n_out] = cyc;
        got[n_out] = a_citxt;
        n_out++;
      end
    end
    a_out_ready = 1'b0;
    a_in_valid = 1'b0;
    chk_i("stream_count", n_out, 3);
    if (n_out == 3 && idx == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("stream_citxt", got[i], ref_aes(st_t[i], st_k[i], 4));
        chk_i("stream_latency", out_cyc[i] - acc_cyc[i], 10);
      end
      chk_i("stream_period_01", out_cyc[1] - out_cyc[0], 12);
      chk_i("stream_period_12", out_cyc[2] - out_cyc[1], 12);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
